mult_div_unit: RTL



---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mult_div_unit_if.sv | 17 +
 rtl/mdu_div_core.sv | 60 ++++++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: command encodings,
// controller states and the default operand width.
package mdu_pkg;

    localparam int MDU_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_NONE = 2'b00,
        MDU_MULT = 2'b01,
        MDU_DIV  = 2'b10
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MULT_CALC = 2'b01,
        DIV_CALC  = 2'b10,
        FINISH    = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if import mdu_pkg::*; #(
    parameter int WIDTH = MDU_DEFAULT_WIDTH
);
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div0;

    modport master (output op, a, b, input hi, lo, busy, done, div0);
    modport slave  (input op, a, b, output hi, lo, busy, done, div0);
endinterface

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step.
// quotient/remainder present the sign-corrected result of the step in progress.
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    start,
    input  logic                    step,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] quotient,
    output logic signed [WIDTH-1:0] remainder
);

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                           input logic neg);
        return neg ? WIDTH'(-m) : WIDTH'(m);
    endfunction

    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             rem_neg;
    logic             quo_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // quo_mag doubles as the dividend shift register: its MSB feeds the remainder
    always_comb begin
        shifted  = {rem_mag, quo_mag[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_mag};
        fits     = !diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_mag[WIDTH-2:0], fits};
    end

    assign quotient  = apply_sign(quo_next, quo_neg);
    assign remainder = apply_sign(rem_next, rem_neg);

    always_ff @(posedge clock) begin
        if (start) begin
            rem_mag <= '0;
            quo_mag <= magnitude(dividend);
            dvs_mag <= magnitude(divisor);
            rem_neg <= dividend[WIDTH-1];
            quo_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        end else if (step) begin
            rem_mag <= rem_next;
            quo_mag <= quo_next;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide unit driving HI/LO.
// Optional macro MDU_ZERO_SKIP_EN: zero operands finish one cycle after the command.
module mult_div_unit import mdu_pkg::*; #(
    parameter int WIDTH = MDU_DEFAULT_WIDTH
) (
    input logic            clock,
    input logic            reset,
    mult_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e              state;
    logic [CNT_W-1:0]        count;
    logic                    last_step;
    logic signed [WIDTH:0]   booth_acc;
    logic signed [WIDTH:0]   booth_m;
    logic [WIDTH-1:0]        booth_q;
    logic                    booth_q1;
    logic signed [WIDTH:0]   booth_sum;
    logic signed [WIDTH:0]   booth_acc_next;
    logic [WIDTH-1:0]        booth_q_next;
    logic                    div_start;
    logic                    div_step;
    logic signed [WIDTH-1:0] div_quo;
    logic signed [WIDTH-1:0] div_rem;
    logic                    mult_skip;
    logic                    div_skip;

`ifdef MDU_ZERO_SKIP_EN
    assign mult_skip = (bus.a == '0) || (bus.b == '0);
    assign div_skip  = (bus.a == '0);
`else
    assign mult_skip = 1'b0;
    assign div_skip  = 1'b0;
`endif

    assign last_step = (count == CNT_W'(WIDTH - 1));
    assign div_start = (state == IDLE) && (bus.op == MDU_DIV) && (bus.b != '0);
    assign div_step  = (state == DIV_CALC);

    // The accumulator carries one guard bit so subtracting the most negative multiplicand cannot wrap
    always_comb begin
        booth_sum = booth_acc;
        case ({booth_q[0], booth_q1})
            2'b10:   booth_sum = booth_acc - booth_m;
            2'b01:   booth_sum = booth_acc + booth_m;
            default: booth_sum = booth_acc;
        endcase
        booth_acc_next = booth_sum >>> 1;
        booth_q_next   = {booth_sum[0], booth_q[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && bus.op == MDU_MULT) begin
            booth_acc <= '0;
            booth_m   <= {bus.a[WIDTH-1], bus.a};
            booth_q   <= bus.b;
            booth_q1  <= 1'b0;
        end else if (state == MULT_CALC) begin
            booth_acc <= booth_acc_next;
            booth_q   <= booth_q_next;
            booth_q1  <= booth_q[0];
        end
    end

    mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clock     (clock),
        .start     (div_start),
        .step      (div_step),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.op == MDU_MULT) begin
                        if (mult_skip) begin
                            bus.hi   <= '0;
                            bus.lo   <= '0;
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            bus.busy <= 1'b1;
                            count    <= '0;
                            state    <= MULT_CALC;
                        end
                    end else if (bus.op == MDU_DIV) begin
                        if (bus.b == '0) begin
                            bus.div0 <= 1'b1;
                            state    <= FINISH;
                        end else if (div_skip) begin
                            bus.hi   <= '0;
                            bus.lo   <= '0;
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            bus.busy <= 1'b1;
                            count    <= '0;
                            state    <= DIV_CALC;
                        end
                    end
                end
                MULT_CALC: begin
                    count <= count + 1'b1;
                    if (last_step) begin
                        {bus.hi, bus.lo} <= {booth_acc_next[WIDTH-1:0], booth_q_next};
                        bus.busy         <= 1'b0;
                        bus.done         <= 1'b1;
                        count            <= '0;
                        state            <= FINISH;
                    end
                end
                DIV_CALC: begin
                    count <= count + 1'b1;
                    if (last_step) begin
                        bus.hi   <= div_rem;
                        bus.lo   <= div_quo;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        count    <= '0;
                        state    <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
